// File: rtl/vram_arbiter_pkg.sv
// Shared types and defaults for the VRAM arbiter: FSM state encoding, default
// widths and a saturating counter helper used by the optional statistics block.
package vram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 19;
  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned STAT_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SETUP = 3'd1,
    ST_RD_DONE  = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_DONE  = 3'd4
  } arbState_t;

  function automatic logic [STAT_W-1:0] satInc16(input logic [STAT_W-1:0] value);
    return (value == '1) ? value : value + STAT_W'(1);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of MCU write stream, scanout read port and SRAM pin signals.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);

  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_strobe;
  logic              wr_overflow;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we_n;
  logic              mem_oe_n;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output wr_addr, wr_data, wr_strobe, rd_req, rd_addr, mem_rdata,
    input  wr_overflow, rd_ack, rd_data, rd_valid,
           mem_addr, mem_wdata, mem_we_n, mem_oe_n
  );

  modport slave (
    input  wr_addr, wr_data, wr_strobe, rd_req, rd_addr, mem_rdata,
    output wr_overflow, rd_ack, rd_data, rd_valid,
           mem_addr, mem_wdata, mem_we_n, mem_oe_n
  );

endinterface

// File: rtl/vram_arbiter_wr_fifo.sv
// Synchronous write FIFO holding {address, data} entries for the arbiter.
// A push while full is accepted when a pop happens on the same edge.
module vram_wr_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   rdPtr_q, rdPtr_d;
  logic             pushEn;
  logic             popEn;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign data_o  = mem_q[rdPtr_q[PTR_W-1:0]];

  assign pushEn = push_i && (!full_o || pop_i);
  assign popEn  = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (pushEn) wrPtr_d = wrPtr_q + PTR_ONE;
    if (popEn)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port video SRAM between the MCU write FIFO and the scanout reads.
// Optional VRAM_ARB_STATS_EN adds saturating write/drop counters as extra outputs.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  vram_arbiter_if.slave     bus
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_wr_cnt,
  output logic [STAT_W-1:0] stat_drop_cnt
`endif
);

  localparam int unsigned FIFO_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

  arbState_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              rdValid_q, rdValid_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic [ADDR_W-1:0] addrIn;
  logic [ADDR_W-1:0] basePtr;
  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [FIFO_W-1:0] fifoDin;
  logic [FIFO_W-1:0] fifoHead;
  logic              unusedWrAddrHi;

  assign addrIn         = bus.wr_addr[ADDR_W-1:0];
  assign unusedWrAddrHi = ^bus.wr_addr[31:ADDR_W];

  // A new MCU base address takes effect in the same cycle, so a coincident strobe uses it.
  always_comb begin
    basePtr    = (addrIn != lastAddr_q) ? addrIn : ptr_q;
    fifoPush   = bus.wr_strobe && (!fifoFull || fifoPop);
    fifoDin    = {basePtr, bus.wr_data};
    ptr_d      = fifoPush ? basePtr + ADDR_W'(1) : basePtr;
    lastAddr_d = addrIn;
    overflow_d = overflow_q | (bus.wr_strobe & ~fifoPush);
  end

  vram_wr_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (sysclk),
    .rst_ni  (rst_n),
    .push_i  (fifoPush),
    .data_i  (fifoDin),
    .pop_i   (fifoPop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_comb begin
    state_d    = state_q;
    fifoPop    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    rdData_d   = rdData_q;
    rdValid_d  = 1'b0;
    starve_d   = fifoEmpty ? '0 : starve_q;
    unique case (state_q)
      ST_IDLE: begin
        // Reads win unless the queued write has already waited STARVE_LIMIT read grants.
        if (!fifoEmpty && (!bus.rd_req || starve_q == CNT_W'(STARVE_LIMIT))) begin
          state_d    = ST_WR_SETUP;
          fifoPop    = 1'b1;
          memAddr_d  = fifoHead[FIFO_W-1:DATA_W];
          memWdata_d = fifoHead[DATA_W-1:0];
          starve_d   = '0;
        end else if (bus.rd_req) begin
          state_d   = ST_RD_SETUP;
          memAddr_d = bus.rd_addr;
          if (!fifoEmpty && starve_q != CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      ST_RD_SETUP: state_d = ST_RD_DONE;
      ST_RD_DONE: begin
        state_d   = ST_IDLE;
        rdData_d  = bus.mem_rdata;
        rdValid_d = 1'b1;
      end
      ST_WR_SETUP: state_d = ST_WR_DONE;
      ST_WR_DONE:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      lastAddr_q <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      rdData_q   <= '0;
      rdValid_q  <= 1'b0;
      overflow_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lastAddr_q <= lastAddr_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      rdData_q   <= rdData_d;
      rdValid_q  <= rdValid_d;
      overflow_q <= overflow_d;
      starve_q   <= starve_d;
    end
  end

  // Strobes decode from state alone, so write and output enables are mutually exclusive.
  assign bus.rd_ack      = (state_q == ST_RD_SETUP);
  assign bus.mem_oe_n    = !((state_q == ST_RD_SETUP) || (state_q == ST_RD_DONE));
  assign bus.mem_we_n    = (state_q != ST_WR_SETUP);
  assign bus.mem_addr    = memAddr_q;
  assign bus.mem_wdata   = memWdata_q;
  assign bus.rd_data     = rdData_q;
  assign bus.rd_valid    = rdValid_q;
  assign bus.wr_overflow = overflow_q;

`ifdef VRAM_ARB_STATS_EN
  logic [STAT_W-1:0] statWr_q;
  logic [STAT_W-1:0] statDrop_q;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      statWr_q   <= '0;
      statDrop_q <= '0;
    end else begin
      if (state_q == ST_WR_SETUP)         statWr_q   <= satInc16(statWr_q);
      if (bus.wr_strobe && !fifoPush)     statDrop_q <= satInc16(statDrop_q);
    end
  end

  assign stat_wr_cnt   = statWr_q;
  assign stat_drop_cnt = statDrop_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: scoreboards for SRAM writes and scanout
// reads, plus scenario tasks for priority, starvation, overflow, wrap and reset.
module tb_vram_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrExp_t;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] statWrCnt;
  logic [15:0] statDropCnt;
`endif

  vram_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stat_wr_cnt   (statWrCnt),
    .stat_drop_cnt (statDropCnt)
`endif
  );

  always #5 sysclk = ~sysclk;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;
  int writesSeen  = 0;

  wrExp_t            writeQ[$];
  int                writeCycleQ[$];
  logic [DATA_W-1:0] rdExpQ[$];
  int                rdAckCycleQ[$];

  logic [ADDR_W-1:0] modelPtr  = '0;
  logic [ADDR_W-1:0] modelLast = '0;
  logic [ADDR_W-1:0] rdAddrReq = '0;

  function automatic logic [DATA_W-1:0] rdPattern(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h7C;
  endfunction

  // SRAM model: returns an address-derived byte while output enable is low.
  assign bus.mem_rdata = (bus.mem_oe_n === 1'b0) ? rdPattern(bus.mem_addr) : 8'h00;

  initial forever begin
    @(posedge sysclk);
    cycle++;
  end

  // SRAM write scoreboard: one compare per WR_SETUP cycle.
  initial forever begin
    wrExp_t exp;
    @(negedge sysclk);
    if (bus.mem_we_n === 1'b0) begin
      writesSeen++;
      writeCycleQ.push_back(cycle);
      testsRun++;
      if (writeQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL sram_write: unexpected write addr=%h data=%h, none required",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        exp = writeQ.pop_front();
        if (bus.mem_addr !== exp.addr || bus.mem_wdata !== exp.data) begin
          testsFailed++;
          $display("[TB] FAIL sram_write: got addr=%h data=%h, required addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, exp.addr, exp.data);
        end
      end
    end
  end

  // Read scoreboard: expected byte queued on rd_ack, checked on rd_valid two cycles later.
  initial forever begin
    logic [DATA_W-1:0] expData;
    int                ackCycle;
    @(negedge sysclk);
    if (bus.rd_ack === 1'b1) begin
      rdExpQ.push_back(rdPattern(rdAddrReq));
      rdAckCycleQ.push_back(cycle);
    end
    if (bus.rd_valid === 1'b1) begin
      testsRun++;
      if (rdExpQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL read_data: unexpected rd_valid data=%h", bus.rd_data);
      end else begin
        expData  = rdExpQ.pop_front();
        ackCycle = rdAckCycleQ.pop_front();
        if (bus.rd_data !== expData || (cycle - ackCycle) != 2) begin
          testsFailed++;
          $display("[TB] FAIL read_data: got data=%h latency=%0d, required data=%h latency=2",
                   bus.rd_data, cycle - ackCycle, expData);
        end
      end
    end
  end

  // Bus invariants checked every cycle out of reset.
  initial forever begin
    @(negedge sysclk);
    if (rst_n === 1'b1) begin
      testsRun++;
      if ((bus.mem_we_n === 1'b0 && bus.mem_oe_n === 1'b0) ||
          (bus.rd_ack === 1'b1 && bus.mem_oe_n !== 1'b0)) begin
        testsFailed++;
        $display("[TB] FAIL bus_invariant: got we_n=%b oe_n=%b rd_ack=%b, required no overlap",
                 bus.mem_we_n, bus.mem_oe_n, bus.rd_ack);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time limit expired, required self-termination");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyReset();
    @(negedge sysclk);
    rst_n         = 1'b0;
    bus.wr_strobe = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    repeat (2) @(negedge sysclk);
    writeQ.delete();
    rdExpQ.delete();
    rdAckCycleQ.delete();
    modelPtr  = '0;
    modelLast = '0;
    rst_n     = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic setWrAddr(input logic [31:0] a);
    bus.wr_addr = a;
    if (a[ADDR_W-1:0] != modelLast) begin
      modelPtr  = a[ADDR_W-1:0];
      modelLast = a[ADDR_W-1:0];
    end
    @(negedge sysclk);
  endtask

  // Drives one strobe cycle starting at a negedge; accepted strobes become expected writes.
  task automatic applyStrobe(input logic [DATA_W-1:0] d, input bit accept);
    bus.wr_strobe = 1'b1;
    bus.wr_data   = d;
    if (accept) begin
      writeQ.push_back('{addr: modelPtr, data: d});
      modelPtr = modelPtr + 1'b1;
    end
    @(negedge sysclk);
    bus.wr_strobe = 1'b0;
  endtask

  task automatic waitDrain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (writeQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
    repeat (4) @(negedge sysclk);
  endtask

  task automatic waitRdAck(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (bus.rd_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge sysclk);
    rst_n         = 1'b0;
    bus.wr_strobe = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    repeat (2) @(negedge sysclk);
    testsRun += 8;
    if (bus.rd_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_ack: got %b, required 0", bus.rd_ack); end
    if (bus.rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_valid: got %b, required 0", bus.rd_valid); end
    if (bus.rd_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_rd_data: got %h, required 00", bus.rd_data); end
    if (bus.mem_addr !== 19'h0) begin testsFailed++; $display("[TB] FAIL reset_mem_addr: got %h, required 0", bus.mem_addr); end
    if (bus.mem_wdata !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_mem_wdata: got %h, required 00", bus.mem_wdata); end
    if (bus.mem_we_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_mem_we_n: got %b, required 1", bus.mem_we_n); end
    if (bus.mem_oe_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_mem_oe_n: got %b, required 1", bus.mem_oe_n); end
    if (bus.wr_overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overflow: got %b, required 0", bus.wr_overflow); end
    rst_n = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic test_write_stream();
    bit ok;
    int startWrites;
    applyReset();
    writeCycleQ.delete();
    startWrites = writesSeen;
    setWrAddr(32'h0000_0100);
    applyStrobe(8'hA1, 1'b1);
    applyStrobe(8'hA2, 1'b1);
    applyStrobe(8'hA3, 1'b1);
    waitDrain(ok);
    testsRun += 2;
    if (!ok) begin testsFailed++; $display("[TB] FAIL write_stream_drain: got %0d pending, required 0", writeQ.size()); end
    if (writesSeen - startWrites != 3) begin
      testsFailed++; $display("[TB] FAIL write_stream_count: got %0d writes, required 3", writesSeen - startWrites);
    end
    if (writeCycleQ.size() == 3) begin
      testsRun += 2;
      if (writeCycleQ[1] - writeCycleQ[0] != 3) begin
        testsFailed++; $display("[TB] FAIL write_stream_gap1: got %0d cycles, required 3", writeCycleQ[1] - writeCycleQ[0]);
      end
      if (writeCycleQ[2] - writeCycleQ[1] != 3) begin
        testsFailed++; $display("[TB] FAIL write_stream_gap2: got %0d cycles, required 3", writeCycleQ[2] - writeCycleQ[1]);
      end
    end
  endtask

  task automatic test_read();
    applyReset();
    rdAddrReq   = 19'h00020;
    bus.rd_addr = 19'h00020;
    bus.rd_req  = 1'b1;
    @(negedge sysclk);
    testsRun += 3;
    if (bus.rd_ack !== 1'b1) begin testsFailed++; $display("[TB] FAIL read_ack: got %b, required 1", bus.rd_ack); end
    if (bus.mem_addr !== 19'h00020) begin testsFailed++; $display("[TB] FAIL read_mem_addr: got %h, required 00020", bus.mem_addr); end
    if (bus.mem_oe_n !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_oe_n: got %b, required 0", bus.mem_oe_n); end
    bus.rd_req = 1'b0;
    @(negedge sysclk);
    testsRun += 2;
    if (bus.rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_valid_early: got %b, required 0", bus.rd_valid); end
    if (bus.rd_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_ack_pulse: got %b, required 0", bus.rd_ack); end
    @(negedge sysclk);
    testsRun += 3;
    if (bus.rd_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL read_valid: got %b, required 1", bus.rd_valid); end
    if (bus.rd_data !== 8'h5C) begin testsFailed++; $display("[TB] FAIL read_value: got %h, required 5c", bus.rd_data); end
    if (bus.mem_oe_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL read_oe_release: got %b, required 1", bus.mem_oe_n); end
    @(negedge sysclk);
    testsRun++;
    if (bus.rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_valid_pulse: got %b, required 0", bus.rd_valid); end
  endtask

  task automatic test_starvation();
    bit ok;
    bit sawWrite;
    int acks;
    applyReset();
    setWrAddr(32'h0000_0400);
    rdAddrReq   = 19'h00033;
    bus.rd_addr = 19'h00033;
    bus.rd_req  = 1'b1;
    waitRdAck(ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL starve_first_ack: got no rd_ack, required one within 20 cycles"); end
    applyStrobe(8'hC3, 1'b1);
    acks     = 0;
    sawWrite = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.mem_we_n === 1'b0) begin
        sawWrite = 1'b1;
        break;
      end
      if (bus.rd_ack === 1'b1) acks++;
      @(negedge sysclk);
    end
    bus.rd_req = 1'b0;
    testsRun += 2;
    if (!sawWrite) begin testsFailed++; $display("[TB] FAIL starve_write_issued: got no write, required one"); end
    if (acks != 8) begin testsFailed++; $display("[TB] FAIL starve_read_grants: got %0d, required 8", acks); end
    waitDrain(ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL starve_drain: got %0d pending, required 0", writeQ.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    int startWrites;
    applyReset();
    startWrites = writesSeen;
    setWrAddr(32'h0007_FFFF);
    applyStrobe(8'hD1, 1'b1);
    applyStrobe(8'hD2, 1'b1);
    waitDrain(ok);
    testsRun += 2;
    if (!ok) begin testsFailed++; $display("[TB] FAIL wrap_drain: got %0d pending, required 0", writeQ.size()); end
    if (writesSeen - startWrites != 2) begin
      testsFailed++; $display("[TB] FAIL wrap_count: got %0d writes, required 2", writesSeen - startWrites);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    applyReset();
    setWrAddr(32'h0000_0200);
    rdAddrReq   = 19'h00044;
    bus.rd_addr = 19'h00044;
    bus.rd_req  = 1'b1;
    waitRdAck(ok);
    testsRun += 2;
    if (!ok) begin testsFailed++; $display("[TB] FAIL overflow_first_ack: got no rd_ack, required one within 20 cycles"); end
    if (bus.wr_overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL overflow_before: got %b, required 0", bus.wr_overflow); end
    for (int i = 0; i < 5; i++) begin
      applyStrobe(8'hB1 + 8'(i), (i < 4));
    end
    bus.rd_req = 1'b0;
    testsRun++;
    if (bus.wr_overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL overflow_set: got %b, required 1", bus.wr_overflow); end
    waitDrain(ok);
    applyStrobe(8'hB6, 1'b1);
    waitDrain(ok);
    testsRun += 2;
    if (!ok) begin testsFailed++; $display("[TB] FAIL overflow_drain: got %0d pending, required 0", writeQ.size()); end
    if (bus.wr_overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL overflow_sticky: got %b, required 1", bus.wr_overflow); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int snapshot;
    setWrAddr(32'h0000_0300);
    applyStrobe(8'hE1, 1'b1);
    applyStrobe(8'hE2, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_we_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL midreset_setup: got no WR_SETUP, required one"); end
    #1;
    writeQ.delete();
    rst_n    = 1'b0;
    snapshot = writesSeen;
    @(negedge sysclk);
    testsRun += 4;
    if (bus.mem_we_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_we_n: got %b, required 1", bus.mem_we_n); end
    if (bus.mem_oe_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_oe_n: got %b, required 1", bus.mem_oe_n); end
    if (bus.wr_overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_overflow: got %b, required 0", bus.wr_overflow); end
    if (bus.rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_rd_valid: got %b, required 0", bus.rd_valid); end
    @(negedge sysclk);
    rst_n     = 1'b1;
    modelPtr  = '0;
    modelLast = '0;
    repeat (20) @(negedge sysclk);
    testsRun++;
    if (writesSeen != snapshot) begin
      testsFailed++; $display("[TB] FAIL midreset_no_writes: got %0d writes after reset, required 0", writesSeen - snapshot);
    end
  endtask

  initial begin
    bus.wr_strobe = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    test_reset();
    test_write_stream();
    test_read();
    test_starvation();
    test_wrap();
    test_overflow();
    test_reset_mid_write();
    repeat (3) @(negedge sysclk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
